// File: rtl/rf_writeback_queue_pkg.sv
// rf_writeback_queue_pkg: shared types and constants for the register-file writeback queue.
// Contents:
//   WORD_W / REG_W : default data-word and register-select widths
//   word_t         : one data word
//   regbits_t      : one register select
//   wb_entry_t     : one buffered write {wsel, wdat}
//   REG_ZERO       : the hardwired zero register; writes to it are dropped
package rf_writeback_queue_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

    localparam regbits_t REG_ZERO = '0;

endpackage

// File: rtl/rf_writeback_queue_fwd_lookup.sv
// wbq_fwd_lookup: combinational youngest-first match of one read select against the
// occupied entries of the writeback FIFO.
// Ports:
//   rsel  in  AW             register being read this cycle
//   head  in  $clog2(DEPTH)  index of the oldest entry
//   count in  $clog2(DEPTH)+1 number of occupied entries
//   sels  in  DEPTH x AW     stored write selects
//   dats  in  DEPTH x DW     stored write data
//   hit   out 1              some occupied entry targets rsel
//   dat   out DW             data of the youngest such entry, 0 on a miss
module wbq_fwd_lookup
    import rf_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = WORD_W,
    parameter int AW    = REG_W,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic [AW-1:0]              rsel,
    input  logic [PW-1:0]              head,
    input  logic [CW-1:0]              count,
    input  logic [DEPTH-1:0][AW-1:0]   sels,
    input  logic [DEPTH-1:0][DW-1:0]   dats,
    output logic                       hit,
    output logic [DW-1:0]              dat
);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overwrites an earlier one.
    always_comb begin
        hit = 1'b0;
        dat = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (rsel != AW'(REG_ZERO) && CW'(i) < count && sels[idx] == rsel) begin
                hit = 1'b1;
                dat = dats[idx];
            end
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order writeback FIFO driving the register file's single write port,
// fed by the load path and the ALU path, with forwarding of still-buffered values.
// Ports:
//   CLK, nRST                      clock (rising edge), asynchronous active-low reset
//   mem_valid/mem_wsel/mem_wdat    load result in;  mem_ready out
//   alu_valid/alu_wsel/alu_wdat    ALU result in;   alu_ready out
//   rf_WEN/rf_wsel/rf_wdat         register file write port (one write per cycle)
//   rsel1/rsel2                    read selects looked up this cycle
//   fwd_hit1/fwd_dat1, fwd_hit2/fwd_dat2  forwarded buffered data per read port
//   count                          occupied entries
module rf_writeback_queue
    import rf_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = WORD_W,
    parameter int AW    = REG_W
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       mem_valid,
    input  logic [AW-1:0]              mem_wsel,
    input  logic [DW-1:0]              mem_wdat,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_wsel,
    input  logic [DW-1:0]              alu_wdat,
    output logic                       alu_ready,
    output logic                       rf_WEN,
    output logic [AW-1:0]              rf_wsel,
    output logic [DW-1:0]              rf_wdat,
    input  logic [AW-1:0]              rsel1,
    input  logic [AW-1:0]              rsel2,
    output logic                       fwd_hit1,
    output logic [DW-1:0]              fwd_dat1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_dat2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [DEPTH-1:0][AW-1:0] sel_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;

    logic          pop;
    logic          mem_nz;
    logic          alu_nz;
    logic          mem_push;
    logic          alu_push;
    logic [CW-1:0] free;
    logic [CW-1:0] alu_need;
    logic [PW-1:0] alu_slot;

    // The register file always accepts, so any occupied head drains this cycle.
    assign pop = (count != '0);

    // Free slots credit the same-cycle pop, so a full queue still takes one push.
    assign free     = CW'(DEPTH) - count + CW'(pop);
    assign mem_nz   = (mem_wsel != AW'(REG_ZERO));
    assign alu_nz   = (alu_wsel != AW'(REG_ZERO));
    assign alu_need = CW'(1) + CW'(mem_valid && mem_nz);

    assign mem_ready = (free >= CW'(1));
    assign alu_ready = (free >= alu_need);

    // Writes to the zero register are handshaken but never buffered.
    assign mem_push = mem_valid && mem_ready && mem_nz;
    assign alu_push = alu_valid && alu_ready && alu_nz;

    // The load is the older instruction, so it takes the tail slot first.
    assign alu_slot = tail + PW'(mem_push);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(mem_push) + PW'(alu_push);
            count <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: only slots covered by count are ever observed.
    always_ff @(posedge CLK) begin
        if (mem_push) begin
            sel_q[tail] <= mem_wsel;
            dat_q[tail] <= mem_wdat;
        end
        if (alu_push) begin
            sel_q[alu_slot] <= alu_wsel;
            dat_q[alu_slot] <= alu_wdat;
        end
    end

    // Driven from count so an asynchronous reset drops the write enable at once.
    assign rf_WEN  = pop;
    assign rf_wsel = pop ? sel_q[head] : '0;
    assign rf_wdat = pop ? dat_q[head] : '0;

    wbq_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fwd1 (
        .rsel  (rsel1),
        .head  (head),
        .count (count),
        .sels  (sel_q),
        .dats  (dat_q),
        .hit   (fwd_hit1),
        .dat   (fwd_dat1)
    );

    wbq_fwd_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_fwd2 (
        .rsel  (rsel2),
        .head  (head),
        .count (count),
        .sels  (sel_q),
        .dats  (dat_q),
        .hit   (fwd_hit2),
        .dat   (fwd_dat2)
    );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed self-checking bench for rf_writeback_queue.
module tb_rf_writeback_queue;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_wsel = '0;
    logic [31:0] mem_wdat = '0;
    logic        mem_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_wsel = '0;
    logic [31:0] alu_wdat = '0;
    logic        alu_ready;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [4:0]  rsel1 = '0;
    logic [4:0]  rsel2 = '0;
    logic        fwd_hit1;
    logic [31:0] fwd_dat1;
    logic        fwd_hit2;
    logic [31:0] fwd_dat2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [36:0] wlog[$];
    logic [36:0] wexp[$];

    rf_writeback_queue dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .mem_valid (mem_valid),
        .mem_wsel  (mem_wsel),
        .mem_wdat  (mem_wdat),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_wsel  (alu_wsel),
        .alu_wdat  (alu_wdat),
        .alu_ready (alu_ready),
        .rf_WEN    (rf_WEN),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .fwd_hit1  (fwd_hit1),
        .fwd_dat1  (fwd_dat1),
        .fwd_hit2  (fwd_hit2),
        .fwd_dat2  (fwd_dat2),
        .count     (count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then record any write the port presents for the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
        if (rf_WEN) wlog.push_back({rf_wsel, rf_wdat});
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        // Reset held with both producers valid
        mem_valid = 1'b1; mem_wsel = 5'd7; mem_wdat = 32'h7;
        alu_valid = 1'b1; alu_wsel = 5'd9; alu_wdat = 32'h9;
        rsel1 = 5'd7;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_wen", rf_WEN, 0);
        chk("rst_count", count, 0);
        chk("rst_hit1", fwd_hit1, 0);
        idle();
        nRST = 1'b1;
        #1;
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);

        // Single ALU write
        alu_valid = 1'b1; alu_wsel = 5'd5; alu_wdat = 32'hDEADBEEF;
        step();
        idle();
        rsel1 = 5'd5;
        #1;
        chk("single_wen", rf_WEN, 1);
        chk("single_wsel", rf_wsel, 5);
        chk("single_wdat", rf_wdat, 32'hDEADBEEF);
        chk("single_hit1", fwd_hit1, 1);
        chk("single_dat1", fwd_dat1, 32'hDEADBEEF);
        chk("single_count", count, 1);
        step();
        chk("single_wen_after", rf_WEN, 0);
        chk("single_count_after", count, 0);
        chk("single_hit1_after", fwd_hit1, 0);

        // Same-register ordering: load older than ALU
        mem_valid = 1'b1; mem_wsel = 5'd3; mem_wdat = 32'h11;
        alu_valid = 1'b1; alu_wsel = 5'd3; alu_wdat = 32'h22;
        #1;
        chk("same_alu_ready", alu_ready, 1);
        step();
        idle();
        rsel2 = 5'd3;
        #1;
        chk("same_w1_wen", rf_WEN, 1);
        chk("same_w1_wsel", rf_wsel, 3);
        chk("same_w1_wdat", rf_wdat, 32'h11);
        chk("same_w1_dat2", fwd_dat2, 32'h22);
        chk("same_w1_count", count, 2);
        step();
        chk("same_w2_wsel", rf_wsel, 3);
        chk("same_w2_wdat", rf_wdat, 32'h22);
        chk("same_w2_dat2", fwd_dat2, 32'h22);
        step();
        chk("same_empty", count, 0);

        // Fill and backpressure; ALU holds its result while not ready
        wlog.delete();
        wexp.delete();
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_wsel = 5'(8 + 2 * k); mem_wdat = 32'h1000 + 32'(8 + 2 * k);
            alu_valid = 1'b1; alu_wsel = 5'(9 + 2 * k); alu_wdat = 32'h1000 + 32'(9 + 2 * k);
            wexp.push_back({mem_wsel, mem_wdat});
            if (k < 3) wexp.push_back({alu_wsel, alu_wdat});
            #1;
            chk($sformatf("fill_mem_ready%0d", k), mem_ready, 1);
            chk($sformatf("fill_alu_ready%0d", k), alu_ready, (k < 3) ? 1 : 0);
            step();
            chk($sformatf("fill_count%0d", k), count, (k == 0) ? 2 : (k == 1) ? 3 : 4);
        end
        mem_valid = 1'b0;
        wexp.push_back({alu_wsel, alu_wdat});
        #1;
        chk("fill_alu_only_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        chk("fill_full_hold", count, 4);
        for (int k = 0; k < 4; k++) step();
        chk("fill_drained", count, 0);
        chk("fill_nwrites", wlog.size(), wexp.size());
        for (int k = 0; k < wexp.size() && k < wlog.size(); k++)
            chk($sformatf("fill_write%0d", k), wlog[k], wexp[k]);

        // Zero register is acknowledged but never written
        alu_valid = 1'b1; alu_wsel = 5'd0; alu_wdat = 32'hFFFF;
        rsel1 = 5'd0;
        #1;
        chk("zero_alu_ready", alu_ready, 1);
        step();
        idle();
        #1;
        chk("zero_count", count, 0);
        chk("zero_wen", rf_WEN, 0);
        chk("zero_hit1", fwd_hit1, 0);
        chk("zero_dat1", fwd_dat1, 0);

        // Asynchronous reset with three writes pending
        mem_valid = 1'b1; mem_wsel = 5'd20; mem_wdat = 32'h20;
        alu_valid = 1'b1; alu_wsel = 5'd21; alu_wdat = 32'h21;
        step();
        mem_wsel = 5'd22; mem_wdat = 32'h22;
        alu_wsel = 5'd23; alu_wdat = 32'h23;
        step();
        idle();
        rsel1 = 5'd23;
        #1;
        chk("mid_count3", count, 3);
        chk("mid_hit_before", fwd_hit1, 1);
        nRST = 1'b0;
        #1;
        chk("mid_wen_async", rf_WEN, 0);
        chk("mid_count_async", count, 0);
        chk("mid_hit_async", fwd_hit1, 0);
        nRST = 1'b1;
        wlog.delete();
        for (int k = 0; k < 3; k++) step();
        chk("mid_no_writes", wlog.size(), 0);
        chk("mid_count_after", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
